// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for the alu_seq execute unit.
// The master drives operations and consumes results; the slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aluResult;
    logic             zero;

    modport master (
        output in_valid, operation, data1, data2, out_ready,
        input  in_ready, out_valid, aluResult, zero
    );

    modport slave (
        input  in_valid, operation, data1, data2, out_ready,
        output in_ready, out_valid, aluResult, zero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU with a valid/ready handshake on both sides.
// Define ALU_SEQ_MULDIV_EN to build iterative MUL/DIVU/REMU; otherwise those opcodes return 0.
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] single_result;
    logic [CW-1:0]    shamt;
    logic             accept;

    assign shamt         = bus.data2[CW-1:0];
    assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.aluResult = result_reg;
    assign bus.zero      = (result_reg == '0);

    // Everything that finishes in one cycle, including divide-by-zero results.
    always_comb begin
        single_result = '0;
        case (bus.operation)
            OP_AND:  single_result = bus.data1 & bus.data2;
            OP_OR:   single_result = bus.data1 | bus.data2;
            OP_ADD:  single_result = bus.data1 + bus.data2;
            OP_XOR:  single_result = bus.data1 ^ bus.data2;
            OP_SUB:  single_result = bus.data1 - bus.data2;
            OP_SLL:  single_result = bus.data1 << shamt;
            OP_SRL:  single_result = bus.data1 >> shamt;
            OP_SRA:  single_result = $signed(bus.data1) >>> shamt;
            OP_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
            OP_SLTU: single_result = {{(WIDTH-1){1'b0}}, (bus.data1 < bus.data2)};
`ifdef ALU_SEQ_MULDIV_EN
            OP_DIVU: single_result = '1;
            OP_REMU: single_result = bus.data1;
`endif
            default: single_result = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // acc: product / partial remainder; a: multiplicand / dividend-then-quotient;
    // b: multiplier / divisor.
    logic [WIDTH-1:0] acc_reg, a_reg, b_reg;
    logic [WIDTH-1:0] acc_next, a_next, b_next;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    count_reg;
    logic             div_reg;
    logic             rem_reg;
    logic             start_iter;

    assign start_iter = (bus.operation == OP_MUL) ||
                        (((bus.operation == OP_DIVU) || (bus.operation == OP_REMU)) &&
                         (bus.data2 != '0));

    always_comb begin
        acc_next = acc_reg;
        a_next   = a_reg;
        b_next   = b_reg;
        trial    = {acc_reg, a_reg[WIDTH-1]} - {1'b0, b_reg};
        if (div_reg) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            a_next   = {a_reg[WIDTH-2:0], ~trial[WIDTH]};
            acc_next = trial[WIDTH] ? {acc_reg[WIDTH-2:0], a_reg[WIDTH-1]} : trial[WIDTH-1:0];
        end else begin
            acc_next = acc_reg + (b_reg[0] ? a_reg : '0);
            a_next   = a_reg << 1;
            b_next   = b_reg >> 1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
`ifdef ALU_SEQ_MULDIV_EN
            count_reg     <= '0;
            acc_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            div_reg       <= 1'b0;
            rem_reg       <= 1'b0;
`endif
        end else if (flush) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            count_reg     <= '0;
`endif
        end else begin
            case (state_reg)
`ifdef ALU_SEQ_MULDIV_EN
                BUSY: begin
                    acc_reg   <= acc_next;
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        count_reg     <= '0;
                        result_reg    <= (div_reg && !rem_reg) ? a_next : acc_next;
                    end
                end
`endif
                default: begin
                    if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
                        if (start_iter) begin
                            state_reg     <= BUSY;
                            out_valid_reg <= 1'b0;
                            count_reg     <= '0;
                            div_reg       <= bus.operation[1];
                            rem_reg       <= bus.operation[0];
                            acc_reg       <= '0;
                            a_reg         <= bus.data1;
                            b_reg         <= bus.data2;
                        end else
`endif
                        begin
                            result_reg    <= single_result;
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end else if ((state_reg == DONE) && bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an 8-bit unit against a cycle-level reference model
// plus directed checks on 8-bit and 64-bit units.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    logic flush8;
    logic flush64;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(64)) bus64 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .flush(flush8),  .bus(bus8));
    alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .flush(flush64), .bus(bus64));

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference result from the opcode table using plain integer arithmetic.
    function automatic logic [7:0] ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, sh, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = ub % 8;
        case (op)
            4'd0:    r = ua & ub;
            4'd1:    r = ua | ub;
            4'd2:    r = ua + ub;
            4'd3:    r = ua ^ ub;
            4'd6:    r = ua - ub;
            4'd4:    r = ua << sh;
            4'd5:    r = ua >> sh;
            4'd7:    r = sa >>> sh;
            4'd8:    r = (sa < sb) ? 1 : 0;
            4'd9:    r = (ua < ub) ? 1 : 0;
            4'd12:   r = MD ? ua * ub : 0;
            4'd14:   r = !MD ? 0 : ((ub == 0) ? 255 : ua / ub);
            4'd15:   r = !MD ? 0 : ((ub == 0) ? ua : ua % ub);
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // Cycles from accept until out_valid: 1 for single-cycle ops, WIDTH+1 for iterative.
    function automatic int ref_lat(input logic [3:0] op, input logic [7:0] b);
        if (MD && ((op == 4'd12) || (((op == 4'd14) || (op == 4'd15)) && (b != 8'd0))))
            return 9;
        return 1;
    endfunction

    // Model of the 8-bit unit: result visible, op in flight, cycles remaining.
    bit         m_valid = 1'b0;
    bit         m_busy  = 1'b0;
    bit         m_ready;
    int         m_left  = 0;
    logic [7:0] m_result = 8'd0;
    logic [7:0] m_pend   = 8'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                m_left  = 0;
            end else begin
                m_ready = !m_busy && (!m_valid || bus8.out_ready);
                chk("model in_ready", 64'(bus8.in_ready), 64'(m_ready));
                chk("model out_valid", 64'(bus8.out_valid), 64'(m_valid));
                if (m_valid) begin
                    chk("model result", 64'(bus8.aluResult), 64'(m_result));
                    chk("model zero", 64'(bus8.zero), 64'(m_result == 8'd0));
                end
                if (flush8) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end else if (bus8.in_valid && m_ready) begin
                    if (ref_lat(bus8.operation, bus8.data2) == 1) begin
                        m_valid  = 1'b1;
                        m_result = ref_op(bus8.operation, bus8.data1, bus8.data2);
                    end else begin
                        m_valid = 1'b0;
                        m_busy  = 1'b1;
                        m_left  = ref_lat(bus8.operation, bus8.data2) - 1;
                        m_pend  = ref_op(bus8.operation, bus8.data1, bus8.data2);
                    end
                end else if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy   = 1'b0;
                        m_valid  = 1'b1;
                        m_result = m_pend;
                    end
                end else if (m_valid && bus8.out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic idle_inputs();
        bus8.in_valid   = 1'b0;
        bus8.operation  = 4'd0;
        bus8.data1      = '0;
        bus8.data2      = '0;
        bus8.out_ready  = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.operation = 4'd0;
        bus64.data1     = '0;
        bus64.data2     = '0;
        bus64.out_ready = 1'b1;
    endtask

    // Issue one op with out_ready high and check result, zero flag and latency literally.
    task automatic issue(input bit wide, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] want, input int want_lat,
                         input string name);
        int         lat;
        bit         seen;
        logic [63:0] res;
        logic       z;
        lat  = 0;
        seen = 1'b0;
        res  = '0;
        z    = 1'b0;
        @(posedge clk); #2;
        if (wide) begin
            bus64.in_valid = 1'b1; bus64.operation = op; bus64.data1 = a; bus64.data2 = b;
            bus64.out_ready = 1'b1;
        end else begin
            bus8.in_valid = 1'b1; bus8.operation = op; bus8.data1 = a[7:0]; bus8.data2 = b[7:0];
            bus8.out_ready = 1'b1;
        end
        @(negedge clk);
        chk({name, " accept"}, 64'(wide ? bus64.in_ready : bus8.in_ready), 64'd1);
        @(posedge clk); #2;
        bus8.in_valid  = 1'b0;
        bus64.in_valid = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i > 1) begin
                @(posedge clk); #2;
            end
            @(negedge clk);
            if (wide ? bus64.out_valid : bus8.out_valid) begin
                seen = 1'b1;
                lat  = i;
                res  = wide ? bus64.aluResult : 64'(bus8.aluResult);
                z    = wide ? bus64.zero : bus8.zero;
            end else if (!wide && want_lat > 1) begin
                chk({name, " busy in_ready"}, 64'(bus8.in_ready), 64'd0);
            end
        end
        chk({name, " latency"}, 64'(lat), 64'(want_lat));
        chk({name, " result"}, res, want);
        chk({name, " zero"}, 64'(z), 64'(want == 64'd0));
    endtask

    int valid_seen;

    initial begin
        reset   = 1'b1;
        flush8  = 1'b0;
        flush64 = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready8", 64'(bus8.in_ready), 64'd1);
        chk("reset out_valid8", 64'(bus8.out_valid), 64'd0);
        chk("reset result8", 64'(bus8.aluResult), 64'd0);
        chk("reset zero8", 64'(bus8.zero), 64'd1);
        chk("reset out_valid64", 64'(bus64.out_valid), 64'd0);
        chk("reset result64", bus64.aluResult, 64'd0);
        chk("reset zero64", 64'(bus64.zero), 64'd1);
        @(posedge clk); #2;
        reset = 1'b0;

        // 64-bit unit
        issue(1'b1, 4'b0010, 64'd5, 64'd7, 64'd12, 1, "w64 add");
        issue(1'b1, 4'b0110, 64'd7, 64'd7, 64'd0, 1, "w64 sub");
        issue(1'b1, 4'b1010, 64'd5, 64'd7, 64'd0, 1, "w64 op1010");
        issue(1'b1, 4'b0111, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1, "w64 sra63");
        issue(1'b1, 4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, "w64 sub wrap");

        // 8-bit unit
        issue(1'b0, 4'b0111, 64'h80, 64'd3, 64'hF0, 1, "sra");
        issue(1'b0, 4'b1000, 64'hFF, 64'h01, 64'd1, 1, "slt");
        issue(1'b0, 4'b1001, 64'hFF, 64'h01, 64'd0, 1, "sltu");
        issue(1'b0, 4'b0100, 64'h01, 64'h09, 64'h02, 1, "sll");
        issue(1'b0, 4'b0101, 64'h80, 64'h0F, 64'h01, 1, "srl");
        issue(1'b0, 4'b0011, 64'hA5, 64'h0F, 64'hAA, 1, "xor");
`ifdef ALU_SEQ_MULDIV_EN
        issue(1'b0, 4'b1100, 64'd13, 64'd11, 64'h8F, 9, "mul");
        issue(1'b0, 4'b1100, 64'hFF, 64'hFF, 64'h01, 9, "mul ff");
        issue(1'b0, 4'b1110, 64'd200, 64'd7, 64'd28, 9, "divu");
        issue(1'b0, 4'b1111, 64'd200, 64'd7, 64'd4, 9, "remu");
        issue(1'b0, 4'b1110, 64'd5, 64'd0, 64'hFF, 1, "divu by0");
        issue(1'b0, 4'b1111, 64'd5, 64'd0, 64'd5, 1, "remu by0");
`else
        issue(1'b0, 4'b1100, 64'd3, 64'd3, 64'd0, 1, "mul off");
        issue(1'b0, 4'b1110, 64'd200, 64'd7, 64'd0, 1, "divu off");
        issue(1'b0, 4'b1111, 64'd200, 64'd7, 64'd0, 1, "remu off");
`endif

        // Back-pressure: result held 5 cycles, then handshake and new accept together.
        @(posedge clk); #2;
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.operation = 4'b0010; bus8.data1 = 8'h10; bus8.data2 = 8'h20;
        @(posedge clk); #2;
        bus8.data1 = 8'd3; bus8.data2 = 8'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold result", 64'(bus8.aluResult), 64'h30);
            chk("hold in_ready", 64'(bus8.in_ready), 64'd0);
            @(posedge clk); #2;
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #2;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("release out_valid", 64'(bus8.out_valid), 64'd1);
        chk("release result", 64'(bus8.aluResult), 64'd7);

        // Flush discards the in-flight or held op.
        @(posedge clk); #2;
`ifdef ALU_SEQ_MULDIV_EN
        bus8.in_valid = 1'b1; bus8.operation = 4'b1110; bus8.data1 = 8'd200; bus8.data2 = 8'd7;
        @(posedge clk); #2;
        bus8.in_valid = 1'b0;
        @(posedge clk); #2;
`else
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.operation = 4'b0010; bus8.data1 = 8'd9; bus8.data2 = 8'd9;
        @(posedge clk); #2;
        bus8.in_valid = 1'b0;
`endif
        @(posedge clk); #2;
        flush8 = 1'b1;
        @(posedge clk); #2;
        flush8 = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("flush in_ready", 64'(bus8.in_ready), 64'd1);
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.out_valid) valid_seen++;
            @(negedge clk);
        end
        chk("flush no out_valid", 64'(valid_seen), 64'd0);
        issue(1'b0, 4'b0010, 64'd1, 64'd1, 64'd2, 1, "add after flush");

        // Asynchronous reset while an op is in flight or held.
        @(posedge clk); #2;
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        bus8.operation = 4'b1100; bus8.data1 = 8'd13; bus8.data2 = 8'd11;
`else
        bus8.operation = 4'b0010; bus8.data1 = 8'h55; bus8.data2 = 8'h11;
`endif
        @(posedge clk); #2;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", 64'(bus8.out_valid), 64'd0);
        chk("async reset result", 64'(bus8.aluResult), 64'd0);
        chk("async reset zero", 64'(bus8.zero), 64'd1);
        chk("async reset in_ready", 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        bus8.out_ready = 1'b1;

        // Random traffic with back-pressure and occasional flush.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #2;
            bus8.in_valid  = ($urandom_range(0, 3) != 0);
            bus8.operation = 4'($urandom_range(0, 15));
            bus8.data1     = 8'($urandom);
            bus8.data2     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            flush8         = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk); #2;
        idle_inputs();
        flush8 = 1'b0;
        repeat (20) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle execute unit for the pipeline's EX stage. It supersedes the single-cycle four-operation ALU. It keeps the existing AND/OR/ADD/SUB opcode encodings and adds shifts, compares and XOR. It also adds iterative multiply and unsigned divide/remainder behind a valid/ready handshake, so the hazard unit can stall on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 64, operand/result width; ≥ 4, power of two.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort of any in-flight or held op.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept this cycle.
- `operation`  in  4  opcode, sampled on accept.
- `data1`, `data2`  in  WIDTH  operands, sampled on accept.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer takes result.
- `aluResult`  out  WIDTH  result.
- `zero`  out  1  `aluResult == 0`, valid with `out_valid`.

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (mod 2^WIDTH); 0011 XOR.
  - 0100 SLL; 0101 SRL; 0111 SRA: shift amount is `data2[log2(WIDTH)-1:0]`.
  - 1000 SLT (signed); 1001 SLTU: result is 1 or 0, zero-extended.
  - 1100 MUL: low WIDTH bits of the product.
  - 1110 DIVU; 1111 REMU: unsigned.
  - All other codes return 0, single-cycle.
- States: IDLE, BUSY, DONE.
- Accept on `in_valid && in_ready`, where `in_ready = (state==IDLE) || (state==DONE && out_ready)`. Operands and opcode are latched at accept.
- Single-cycle op: result is registered at the accept edge; next state DONE.
- MUL: shift-add, one multiplier bit per cycle. Next state BUSY with iteration counter = 0. Each BUSY edge performs one step and increments the counter. On the edge completing step WIDTH-1, go to DONE.
- DIVU/REMU: restoring divide, one quotient bit per cycle, same counter and transitions as MUL.
- Divide by zero bypasses BUSY and completes single-cycle:
  - DIVU returns all ones.
  - REMU returns `data1`.
- DONE: `out_valid`=1; `aluResult`/`zero` are held stable until handshake.
  - On `out_valid && out_ready` without a new accept, go to IDLE.
  - On a simultaneous accept, follow the new op's path.
- Flush has priority over all other events. At the next edge: state IDLE, `out_valid`=0, counter cleared; any accept that cycle is discarded. `in_ready` still reflects state while `flush` is high.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `aluResult`=0, `zero`=1, counter 0.
- Single-cycle op: `out_valid` is high in the cycle after the accept edge (latency 1). Back-to-back accepts with `out_ready` held high give throughput of 1 op/cycle.
- MUL/DIVU/REMU: `out_valid` is asserted WIDTH+1 cycles after the accept edge. `in_ready`=0 throughout BUSY.
- `out_valid` never drops without a handshake, flush or reset. `aluResult` must not change while `out_valid`=1 and `out_ready`=0.
- Asserting `reset` mid-BUSY returns all outputs to reset values immediately. No partial result is ever presented.
- Counter width is log2(WIDTH); it must not wrap during an op.
- `zero` is computed from the registered result.

## Configuration
- `ALU_SEQ_MULDIV_EN`
- Defined: MUL, DIVU and REMU are implemented as above, and the BUSY state exists.
- Undefined:
  - 1100, 1110 and 1111 behave as unknown opcodes: result 0, latency 1.
  - The multiply/divide datapath and counter are not synthesised.
  - BUSY is unreachable; `in_ready` depends only on IDLE/DONE.

## Test plan
- Reset, then with WIDTH=64: ADD 5+7 -> 12, `zero`=0. SUB 7-7 -> 0, `zero`=1. Opcode 1010 -> 0. Each has `out_valid` one cycle after accept.
- WIDTH=8, SRA 0x80 by 3 -> 0xF0. SLT 0xFF<0x01 -> 1. SLTU 0xFF<0x01 -> 0. SLL 0x01 by data2=0x09 (amount 1) -> 0x02.
- WIDTH=8, MUL 13×11 -> 0x8F, with `out_valid` 9 cycles after accept and `in_ready`=0 during BUSY. DIVU 200/7 -> 28. REMU 200/7 -> 4. DIVU 5/0 -> 0xFF and REMU 5/0 -> 5, each with latency 1.
- Hold `out_ready`=0 for 5 cycles after any result: `aluResult` stays stable and `in_ready`=0. Then pulse `out_ready` together with `in_valid` carrying a new ADD: the new op is accepted and the next result appears the following cycle.
- Flush on the 3rd BUSY cycle of DIVU: next cycle IDLE, `out_valid` never asserts. A following ADD 1+1 -> 2 with normal latency.
- Assert `reset` mid-MUL: `out_valid`=0 and `aluResult`=0 immediately. With `ALU_SEQ_MULDIV_EN` undefined, MUL 3×3 -> 0 at latency 1.
